// File: rtl/pipelined_addsub_if.sv
// Operand/result bus for pipelined_addsub.
// Two valid/ready handshakes share one bundle:
//   in_*  : operand beat (in_valid/in_ready, in_a, in_b, in_cin, in_sub)
//   out_* : result beat  (out_valid/out_ready, out_sum, out_cout, out_ovf)
// master : operand source / result consumer side
// slave  : the adder/subtractor itself
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor.
// WIDTH-bit operands are cut into STAGES chunks of CW = WIDTH/STAGES bits. Stage k
// adds chunk k plus the carry registered by stage k-1, so the critical path is one
// CW-bit ripple regardless of WIDTH.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset; clears every valid/data register
//   bus.in_valid   operand beat present        bus.in_ready  = !out_valid | out_ready
//   bus.in_a/in_b  operands                    bus.in_cin    carry-in / not-borrow-in
//   bus.in_sub     1: A + ~B + cin
//   bus.out_valid  result beat present         bus.out_ready consumer accepts result
//   bus.out_sum    result mod 2^WIDTH          bus.out_cout  carry out of MSB
//   bus.out_ovf    signed overflow (carry into MSB ^ carry out of MSB)
// Latency is STAGES advancing cycles; the whole pipe stalls as one unit.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_addsub_if.slave bus
);

  localparam int unsigned CW = WIDTH / STAGES;

  // Reject geometries that cannot be split into equal chunks.
  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end

  // Global advance enable: every register in the pipe moves together.
  logic             en;
  logic [WIDTH-1:0] b_eff;

  assign en    = ~g_stg[STAGES-1].v_q | bus.out_ready;
  assign b_eff = bus.in_b ^ {WIDTH{bus.in_sub}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Sum bits already resolved once a beat has left this stage.
    localparam int unsigned LO_W = (k + 1) * CW;

    logic            v_in;
    logic            c_in;
    logic [CW-1:0]   a_ch;
    logic [CW-1:0]   b_ch;
    logic [CW:0]     add_c;
    logic [LO_W-1:0] s_d;

    logic            v_q;
    logic            c_q;
    logic [LO_W-1:0] s_q;

    // One CW-bit slice of the ripple chain.
    assign add_c = {1'b0, a_ch} + {1'b0, b_ch} + {{CW{1'b0}}, c_in};

    if (k == 0) begin : g_src
      assign v_in = bus.in_valid;
      assign c_in = bus.in_cin;
      assign a_ch = bus.in_a[CW-1:0];
      assign b_ch = b_eff[CW-1:0];
      assign s_d  = add_c[CW-1:0];
    end else begin : g_src
      // Operand chunk k arrives skew-delayed; lower sum chunks travel alongside.
      assign v_in = g_stg[k-1].v_q;
      assign c_in = g_stg[k-1].c_q;
      assign a_ch = g_stg[k-1].g_skew.a_q[CW-1:0];
      assign b_ch = g_stg[k-1].g_skew.b_q[CW-1:0];
      assign s_d  = {add_c[CW-1:0], g_stg[k-1].s_q};
    end

    // Valid, chunk carry and de-skewed partial sum.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= add_c[CW];
        s_q <= s_d;
      end
    end

    // Operand chunks not yet consumed by this stage.
    if (k < STAGES - 1) begin : g_skew
      localparam int unsigned HI_W = (STAGES - 1 - k) * CW;

      logic [HI_W-1:0] a_d;
      logic [HI_W-1:0] b_d;
      logic [HI_W-1:0] a_q;
      logic [HI_W-1:0] b_q;

      if (k == 0) begin : g_src
        assign a_d = bus.in_a[WIDTH-1:CW];
        assign b_d = b_eff[WIDTH-1:CW];
      end else begin : g_src
        assign a_d = g_stg[k-1].g_skew.a_q[HI_W+CW-1:CW];
        assign b_d = g_stg[k-1].g_skew.b_q[HI_W+CW-1:CW];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    // Final stage also sees the MSB slice, so it owns signed overflow.
    if (k == STAGES - 1) begin : g_tail
      logic c_msb;
      logic ovf_q;

      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
      assign c_msb = a_ch[CW-1] ^ b_ch[CW-1] ^ add_c[CW-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c_msb ^ add_c[CW];
        end
      end
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = g_stg[STAGES-1].v_q;
  assign bus.out_sum   = g_stg[STAGES-1].s_q;
  assign bus.out_cout  = g_stg[STAGES-1].c_q;
  assign bus.out_ovf   = g_stg[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=16, STAGES=4): directed corner cases, backpressure,
// mid-flight reset and a long random run against an arithmetic scoreboard.
module tb_pipelined_addsub;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic clk;
  logic rst;

  pipelined_addsub_if #(.WIDTH(W)) bus ();

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           nvec;
  int           nerr;
  logic [W+1:0] exp_q[$];
  logic         held;
  logic [W+1:0] held_v;
  int           stall_run;
  int           stall_max;
  int           cov_sub;
  int           cov_ovf;

  // Reference: plain integer arithmetic, {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] be;
    longint       u;
    longint       s;
    logic         ovf;
    logic [W:0]   us;
    be  = sub ? ~b : b;
    u   = longint'(a) + longint'(be) + longint'(cin);
    s   = longint'($signed(a)) + longint'($signed(be)) + longint'(cin);
    ovf = (s > 32767) || (s < -32768);
    us  = (W+1)'(u);
    return {ovf, us};
  endfunction

  function automatic logic [W+1:0] outs();
    return {bus.out_ovf, bus.out_cout, bus.out_sum};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic ordy);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = cin;
    bus.in_sub    = sub;
    bus.out_ready = ordy;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_a      = 'x;
    bus.in_b      = 'x;
    bus.in_cin    = 1'bx;
    bus.in_sub    = 1'bx;
    bus.out_ready = 1'b1;
  endtask

  // One clock: scoreboard bookkeeping at the falling edge, return just after the rise.
  task automatic tick();
    logic [W+1:0] e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      held      = 1'b0;
      stall_run = 0;
    end else begin
      chk("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (held) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(outs()), 32'(held_v));
      end
      held   = bus.out_valid && !bus.out_ready;
      held_v = outs();
      if (held) begin
        stall_run++;
        if (stall_run > stall_max) stall_max = stall_run;
      end else begin
        stall_run = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e[W+1]) cov_ovf++;
          chk("result", 32'(outs()), 32'(e));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
        if (bus.in_sub) cov_sub++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Single beat through an empty pipe: exact latency and result fields.
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         input logic [W-1:0] es, input logic ec, input logic eo);
    drive(1'b1, a, b, cin, sub, 1'b1);
    tick();
    idle();
    tick();
    tick();
    chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(bus.out_sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus.out_cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eo));
    tick();
  endtask

  // Watchdog so a wedged pipe still terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int got;
    int accepted;
    int guard;
    int stall_left;
    logic [W-1:0] ra;

    nvec = 0; nerr = 0; held = 1'b0; held_v = '0;
    stall_run = 0; stall_max = 0; cov_sub = 0; cov_ovf = 0;

    // Reset state.
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_cout", 32'(bus.out_cout), 32'd0);
    chk("rst_ovf", 32'(bus.out_ovf), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    // Directed arithmetic corners.
    run_one("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("ovf_neg",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_one("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_plain",  16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

    // Backpressure: 8 beats A=B=i, consumer stalls in cycles 6..8.
    i = 1;
    got = 0;
    for (int c = 1; c <= 40 && got < 8; c++) begin
      if (i <= 8) begin
        drive(1'b1, W'(i), W'(i), 1'b0, 1'b0, !(c >= 6 && c <= 8));
      end else begin
        idle();
        bus.out_ready = !(c >= 6 && c <= 8);
      end
      #1;
      if (c >= 6 && c <= 8) begin
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_sum", 32'(bus.out_sum), 32'h0004);
      end
      if (got > 0 && bus.out_ready) chk("bp_nogap", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid && bus.out_ready) begin
        got++;
        chk("bp_order", 32'(bus.out_sum), 32'(2 * got));
      end
      if (bus.in_valid && bus.in_ready) i++;
      tick();
    end
    chk("bp_count", 32'(got), 32'd8);
    idle();
    tick();

    // Reset with three beats in flight: none may ever surface.
    for (int j = 1; j <= 3; j++) begin
      drive(1'b1, W'(j * 16'h1111), 16'h0001, 1'b0, 1'b0, 1'b1);
      tick();
    end
    chk("mf_accepted", 32'(exp_q.size()), 32'd3);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mf_valid", 32'(bus.out_valid), 32'd0);
    chk("mf_sum", 32'(bus.out_sum), 32'd0);
    chk("mf_cout", 32'(bus.out_cout), 32'd0);
    chk("mf_ovf", 32'(bus.out_ovf), 32'd0);
    chk("mf_in_ready", 32'(bus.in_ready), 32'd1);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("mf_no_ghost", 32'(bus.out_valid), 32'd0);
    end

    // Random traffic: 10k accepted beats, random valid/ready, occasional 4-cycle stall.
    accepted = 0;
    guard = 0;
    stall_left = 0;
    while (accepted < 10000 && guard < 60000) begin
      case ($urandom_range(0, 7))
        0:       ra = 16'h7FFF;
        1:       ra = 16'h8000;
        2:       ra = 16'hFFFF;
        default: ra = W'($urandom);
      endcase
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_a     = ra;
      bus.in_b     = W'($urandom);
      bus.in_cin   = 1'($urandom);
      bus.in_sub   = 1'($urandom);
      if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 199) == 0) begin
        bus.out_ready = 1'b0;
        stall_left = 3;
      end else begin
        bus.out_ready = ($urandom_range(0, 9) < 7);
      end
      #1;
      if (bus.in_valid && bus.in_ready) accepted++;
      tick();
      guard++;
    end
    chk("rand_accepted", 32'(accepted), 32'd10000);

    // Drain the pipe, bounded.
    idle();
    for (int j = 0; j < 64 && exp_q.size() > 0; j++) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    tick();
    chk("drain_idle", 32'(bus.out_valid), 32'd0);

    // Coverage goals reached by the random run.
    chk("cov_sub", 32'(cov_sub > 0), 32'd1);
    chk("cov_ovf", 32'(cov_ovf > 0), 32'd1);
    chk("cov_stall4", 32'(stall_max >= 4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
